// File: rtl/mux2n1_arbiter.sv
// Round-robin two-source arbiter that owns the 2:1 operand mux select and registers the granted data.
// Optional MUX2N1_ARB_HOLD_LIMIT_EN caps consecutive beats per ownership when the other source waits.
module mux2n1_arbiter #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Req0,
  input  logic [WIDTH-1:0] Input0,
  input  logic             Req1,
  input  logic [WIDTH-1:0] Input1,
  input  logic             Ready,
  output logic             Gnt0,
  output logic             Gnt1,
  output logic             Ack0,
  output logic             Ack1,
  output logic             Sel,
  output logic [WIDTH-1:0] Out,
  output logic             Valid
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN0 = 2'd1;
  localparam logic [1:0] OWN1 = 2'd2;

  if (MAX_HOLD < 1 || MAX_HOLD > 15) begin : g_bad_max_hold
    $error("mux2n1_arbiter: MAX_HOLD must be in 1..15");
  end

  logic [1:0]       state_q, state_d;
  logic             last_q, last_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             valid_q, valid_d;
  logic             free;

  assign Gnt0  = (state_q == OWN0);
  assign Gnt1  = (state_q == OWN1);
  assign Sel   = Gnt1;
  assign free  = !valid_q || Ready;
  assign Ack0  = Gnt0 && Req0 && free;
  assign Ack1  = Gnt1 && Req1 && free;
  assign Out   = out_q;
  assign Valid = valid_q;

`ifdef MUX2N1_ARB_HOLD_LIMIT_EN
  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  logic [3:0] hold_q, hold_d;
  logic       hold_hit;

  assign hold_hit = (hold_q == HOLD_LAST);
`endif

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        // On a tie, the source that was not served last wins.
        if (Req0 && Req1) begin
          if (last_q) begin
            state_d = OWN0;
            last_d  = 1'b0;
          end else begin
            state_d = OWN1;
            last_d  = 1'b1;
          end
        end else if (Req0) begin
          state_d = OWN0;
          last_d  = 1'b0;
        end else if (Req1) begin
          state_d = OWN1;
          last_d  = 1'b1;
        end
      end
      OWN0: begin
        if (!Req0) begin
          if (Req1) begin
            state_d = OWN1;
            last_d  = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
`ifdef MUX2N1_ARB_HOLD_LIMIT_EN
        else if (Ack0 && hold_hit && Req1) begin
          state_d = OWN1;
          last_d  = 1'b1;
        end
`endif
      end
      OWN1: begin
        if (!Req1) begin
          if (Req0) begin
            state_d = OWN0;
            last_d  = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
`ifdef MUX2N1_ARB_HOLD_LIMIT_EN
        else if (Ack1 && hold_hit && Req0) begin
          state_d = OWN0;
          last_d  = 1'b0;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef MUX2N1_ARB_HOLD_LIMIT_EN
  always_comb begin
    hold_d = hold_q;
    if (state_d != state_q) begin
      hold_d = '0;
    end else if ((Ack0 || Ack1) && hold_q != 4'hF) begin
      hold_d = hold_q + 4'd1;
    end
  end
`endif

  always_comb begin
    out_d   = out_q;
    valid_d = valid_q;
    if (Ack0) begin
      out_d   = Input0;
      valid_d = 1'b1;
    end else if (Ack1) begin
      out_d   = Input1;
      valid_d = 1'b1;
    end else if (free) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

`ifdef MUX2N1_ARB_HOLD_LIMIT_EN
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end
`endif

endmodule

// File: tb/tb_mux2n1_arbiter.sv
// Bench for mux2n1_arbiter: directed vector table, async-reset and hold-limit sequences, random vs. reference model.
module tb_mux2n1_arbiter;
  localparam int MH = 4;
  localparam int W  = 4;
`ifdef MUX2N1_ARB_HOLD_LIMIT_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  logic         Clock = 1'b0;
  logic         Reset = 1'b1;
  logic         Req0 = 1'b0, Req1 = 1'b0, Ready = 1'b0;
  logic [W-1:0] Input0 = '0, Input1 = '0;
  logic         Gnt0, Gnt1, Ack0, Ack1, Sel, Valid;
  logic [W-1:0] Out;
  logic [9:0]   obs;

  mux2n1_arbiter #(.WIDTH(W), .MAX_HOLD(MH)) dut (
    .Clock(Clock), .Reset(Reset),
    .Req0(Req0), .Input0(Input0), .Req1(Req1), .Input1(Input1),
    .Ready(Ready),
    .Gnt0(Gnt0), .Gnt1(Gnt1), .Ack0(Ack0), .Ack1(Ack1), .Sel(Sel),
    .Out(Out), .Valid(Valid)
  );

  always #5 Clock = ~Clock;

  // Observed vector layout: {Gnt0, Gnt1, Ack0, Ack1, Sel, Valid, Out}
  assign obs = {Gnt0, Gnt1, Ack0, Ack1, Sel, Valid, Out};

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit         rst;
    bit         r0;
    logic [3:0] i0;
    bit         r1;
    logic [3:0] i1;
    bit         rdy;
    logic [9:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [9:0] got, input logic [9:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b expected=%b at %0t", name, got, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge Clock);
    #1;
  endtask

  task automatic add(input bit rst, input bit r0, input logic [3:0] i0, input bit r1,
                     input logic [3:0] i1, input bit rdy, input bit g0, input bit g1,
                     input bit a0, input bit a1, input bit sel, input bit v,
                     input logic [3:0] o);
    vec_t t;
    t.rst = rst; t.r0 = r0; t.i0 = i0; t.r1 = r1; t.i1 = i1; t.rdy = rdy;
    t.exp = {g0, g1, a0, a1, sel, v, o};
    vecs.push_back(t);
  endtask

  // Reference model state
  int         m_owner;
  int         m_last;
  int         m_cnt;
  logic [3:0] m_out;
  bit         m_valid;

  initial begin
    //  rst r0 i0    r1 i1    rdy  g0 g1 a0 a1 sel v out
    add(0,  1, 4'hA, 0, 4'h0, 1,   0, 0, 0, 0, 0, 0, 4'h0);
    add(0,  1, 4'hA, 0, 4'h0, 1,   1, 0, 1, 0, 0, 0, 4'h0);
    add(0,  0, 4'hA, 0, 4'h0, 1,   1, 0, 0, 0, 0, 1, 4'hA);
    add(0,  0, 4'hA, 0, 4'h0, 1,   0, 0, 0, 0, 0, 0, 4'hA);
    add(1,  0, 4'h0, 0, 4'h0, 1,   0, 0, 0, 0, 0, 0, 4'h0);
    add(0,  1, 4'h1, 1, 4'h2, 1,   0, 0, 0, 0, 0, 0, 4'h0);
    add(0,  1, 4'h1, 1, 4'h2, 1,   1, 0, 1, 0, 0, 0, 4'h0);
    add(0,  0, 4'h1, 1, 4'h2, 1,   1, 0, 0, 0, 0, 1, 4'h1);
    add(0,  0, 4'h1, 1, 4'h2, 1,   0, 1, 0, 1, 1, 0, 4'h1);
    add(0,  0, 4'h1, 0, 4'h2, 1,   0, 1, 0, 0, 1, 1, 4'h2);
    add(0,  1, 4'h1, 1, 4'h2, 1,   0, 0, 0, 0, 0, 0, 4'h2);
    add(0,  1, 4'h1, 1, 4'h2, 1,   1, 0, 1, 0, 0, 0, 4'h2);
    add(0,  0, 4'h1, 0, 4'h2, 1,   1, 0, 0, 0, 0, 1, 4'h1);
    add(0,  0, 4'h1, 0, 4'h2, 1,   0, 0, 0, 0, 0, 0, 4'h1);
    add(0,  0, 4'h0, 1, 4'h3, 1,   0, 0, 0, 0, 0, 0, 4'h1);
    add(0,  0, 4'h0, 1, 4'h3, 1,   0, 1, 0, 1, 1, 0, 4'h1);
    add(0,  0, 4'h0, 1, 4'h5, 0,   0, 1, 0, 0, 1, 1, 4'h3);
    add(0,  0, 4'h0, 1, 4'h5, 0,   0, 1, 0, 0, 1, 1, 4'h3);
    add(0,  0, 4'h0, 1, 4'h5, 1,   0, 1, 0, 1, 1, 1, 4'h3);
    add(0,  0, 4'h0, 1, 4'h7, 1,   0, 1, 0, 1, 1, 1, 4'h5);
    add(0,  0, 4'h0, 0, 4'h7, 1,   0, 1, 0, 0, 1, 1, 4'h7);
    add(0,  0, 4'h0, 0, 4'h7, 1,   0, 0, 0, 0, 0, 0, 4'h7);

    Reset = 1'b1;
    repeat (2) @(posedge Clock);
    #1;
    Reset = 1'b0;

    foreach (vecs[n]) begin
      Reset  = vecs[n].rst;
      Req0   = vecs[n].r0;
      Input0 = vecs[n].i0;
      Req1   = vecs[n].r1;
      Input1 = vecs[n].i1;
      Ready  = vecs[n].rdy;
      #3;
      check($sformatf("vec%0d", n), obs, vecs[n].exp);
      next_cycle();
    end
    Reset = 1'b0;

    // Async reset in the middle of a source-0 stream
    Req0 = 1'b1; Input0 = 4'h9; Req1 = 1'b0; Ready = 1'b1;
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 6 && !seen; i++) begin
        #3;
        seen = Valid && (Out == 4'h9);
        if (!seen) next_cycle();
      end
    end
    check("stream_valid", 10'({Valid, Out}), 10'h019);
    #2;
    Reset = 1'b1;
    #1;
    check("async_reset", obs, 10'h000);
    next_cycle();
    Reset = 1'b0; Req0 = 1'b0; Req1 = 1'b1; Input1 = 4'h6;
    #3;
    check("post_reset_idle", obs, 10'h000);
    next_cycle();
    #3;
    check("post_reset_gnt1", obs, 10'b01_0_1_1_0_0000);
    next_cycle();

    // Both sources saturating: hold-limit alternation or permanent owner 0
    Req0 = 1'b0; Req1 = 1'b0;
    Reset = 1'b1;
    next_cycle();
    Reset = 1'b0; Req0 = 1'b1; Req1 = 1'b1; Ready = 1'b1;
    for (int c = 0; c < 24; c++) begin
      logic [9:0] e;
      int o;
      Input0 = 4'(c); Input1 = 4'(~c);
      #3;
      if (c == 0) begin
        e = '0;
      end else begin
        o = HOLD_EN ? ((c - 1) / MH) % 2 : 0;
        e = {(o == 0), (o == 1), (o == 0), (o == 1), 6'b0};
      end
      check($sformatf("hold%0d", c), {obs[9:6], 6'b0}, e);
      next_cycle();
    end

    // Randomised traffic against the reference model
    Req0 = 1'b0; Req1 = 1'b0;
    Reset = 1'b1;
    next_cycle();
    Reset = 1'b0;
    m_owner = -1; m_last = 1; m_cnt = 0; m_out = '0; m_valid = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      bit         rq[2];
      logic [3:0] in[2];
      bit         ack[2];
      bit         fr;
      int         nxt;
      if ($urandom_range(3) == 0) Req0 = ~Req0;
      if ($urandom_range(3) == 0) Req1 = ~Req1;
      Ready  = ($urandom_range(3) != 0);
      Input0 = 4'($urandom);
      Input1 = 4'($urandom);
      #3;
      rq[0] = Req0; rq[1] = Req1; in[0] = Input0; in[1] = Input1;
      fr = !m_valid || Ready;
      for (int s = 0; s < 2; s++) ack[s] = (m_owner == s) && rq[s] && fr;
      check("random", obs, {(m_owner == 0), (m_owner == 1), ack[0], ack[1],
                            (m_owner == 1), m_valid, m_out});
      if (ack[0] || ack[1]) begin
        m_out   = ack[0] ? in[0] : in[1];
        m_valid = 1'b1;
      end else if (fr) begin
        m_valid = 1'b0;
      end
      nxt = m_owner;
      if (m_owner < 0) begin
        if (rq[0] && rq[1]) nxt = 1 - m_last;
        else if (rq[0])     nxt = 0;
        else if (rq[1])     nxt = 1;
      end else if (!rq[m_owner]) begin
        nxt = rq[1 - m_owner] ? 1 - m_owner : -1;
      end else if (HOLD_EN && ack[m_owner] && m_cnt == MH - 1 && rq[1 - m_owner]) begin
        nxt = 1 - m_owner;
      end
      if (nxt != m_owner) begin
        m_cnt = 0;
        if (nxt >= 0) m_last = nxt;
      end else if (m_owner >= 0 && ack[m_owner]) begin
        m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
      end
      m_owner = nxt;
      next_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mux2n1_arbiter.md
# mux2n1_arbiter

Two-requester arbiter and output register that owns the select line of a 2:1 4-bit operand mux in the single-cycle CPU datapath. Two sources (for example, a register-address source and a debug/override source) each request the shared mux path. The block grants one source at a time with round-robin fairness. It captures the granted source's data into a registered output under a valid/ready handshake and drives the mux select.

## Interface
Parameters:
- WIDTH, 4, data width of Input0/Input1/Out
- MAX_HOLD, 8, maximum accepted beats per ownership when the other source is waiting (only used with MUX2N1_ARB_HOLD_LIMIT_EN); range 1..15

Ports:
- Clock  input  1  single clock, rising edge
- Reset  input  1  asynchronous, active-high
- Req0  input  1  source 0 requests the path
- Input0  input  WIDTH  source 0 data
- Req1  input  1  source 1 requests the path
- Input1  input  WIDTH  source 1 data
- Ready  input  1  consumer accepts Out this cycle
- Gnt0  output  1  source 0 owns the path (state decode)
- Gnt1  output  1  source 1 owns the path (state decode)
- Ack0  output  1  Input0 captured at this edge (combinational)
- Ack1  output  1  Input1 captured at this edge (combinational)
- Sel  output  1  mux select: 1 only while Gnt1
- Out  output  WIDTH  registered captured data
- Valid  output  1  Out holds an unconsumed beat

## Operation
- State register: IDLE, OWN0, OWN1. Last-served pointer Last: 1 bit.
- Gnt0 = (state==OWN0); Gnt1 = (state==OWN1); Sel = Gnt1.
- Slot free: Free = !Valid | Ready.
- AckX = GntX & ReqX & Free. Source X may change InputX only after a cycle with AckX=1.
- Capture: at an edge with AckX, Out <= InputX and Valid <= 1. At an edge with Free and no Ack, Valid <= 0 and Out is held.
- Ready low with Valid high: Out and Valid hold; no Ack.
- IDLE:
  - Only Req0 -> OWN0, Last<=0.
  - Only Req1 -> OWN1, Last<=1.
  - Both requesting -> grant the source != Last.
  - Neither -> stay in IDLE.
- OWNx, ReqX low at the edge:
  - Other Req high -> OWNy directly (no IDLE bubble), Last<=y.
  - Otherwise -> IDLE.
- OWNx, ReqX high: stay in OWNx, except for the hold-limit switch in Configuration.
- HoldCnt (4 bit): cleared on every ownership change and counts Acks in the current ownership. It saturates at 15.
- Reset values: state IDLE, Gnt0=Gnt1=0, Sel=0, Ack0=Ack1=0, Out=0, Valid=0, Last=1, HoldCnt=0.
  - Last=1 at reset means Req0 wins the first tie.
- Reset asserted mid-operation discards any pending beat and grant immediately, without waiting for a clock edge.

## Timing
- Req sampled at edge k -> Gnt high from edge k onward (cycle k+1).
- Earliest Ack is in cycle k+1; Valid rises after edge k+1.
- Request-to-first-Valid latency: 2 cycles.
- Throughput: 1 beat/cycle while ReqX and Ready stay high.
- Handover: last Ack from X at edge n with ReqX dropping at edge n+1 -> Gnt y from edge n+1, first Ack y in cycle n+2. This gives one dead cycle for X deassert.
- Ack is a combinational function of registered state and Ready/Req. There is no combinational path from Input* to any output except through Out's register.

## Configuration
- MUX2N1_ARB_HOLD_LIMIT_EN defined:
  - In OWNx, an edge with AckX where HoldCnt==MAX_HOLD-1 and the other Req high forces a switch to OWNy (Last<=y), even though ReqX stays high.
  - The owner regains the path through normal round-robin.
- Not defined: the owner holds the path as long as ReqX stays high, and HoldCnt logic is removed.

## Test plan
- Reset then Req0=1, Input0=4'hA, Ready=1 -> Gnt0 in cycle 1, Ack0 in cycle 1, Out=4'hA with Valid=1 in cycle 2, Sel=0 throughout.
- Req0 and Req1 rise together after reset -> OWN0 first. After Req0 drops, OWN1 follows with no IDLE cycle and Sel=1. Next simultaneous tie grants source 0.
- OWN1 streaming 3,5,7 with Ready low for 2 cycles after the first beat -> Out=3 held with Valid=1 and Ack1=0 while stalled. The remaining beats 5,7 then arrive in order.
- With MUX2N1_ARB_HOLD_LIMIT_EN and MAX_HOLD=4, Req0 and Req1 held high -> exactly 4 Ack0 beats, then Gnt1 for 4 beats, alternating. Without the macro, Gnt0 persists indefinitely.
- Reset asserted asynchronously mid-stream (Valid=1, Out=4'h9) -> Out=0, Valid=0, Gnt0=Gnt1=0, Sel=0 before the next clock edge. After reset release, Req1 alone -> Gnt1 in the next cycle.
